// File: rtl/alu_multicycle.sv
// Purpose : MIPS-style ALU; logic/shift/add/slt in one cycle, iterative signed mul/div.
// Latency : 1 edge for single-cycle ops; WIDTH+2 edges for mul/div; 2 edges for div by zero.
// Backpr. : none; start is only sampled in IDLE, so starts while busy are dropped.
//
// Ports:
//   clk, reset           single rising-edge clock, synchronous active-high reset
//   start, operation     request + 4-bit op code, sampled only while idle
//   a, b, shamt          operands (rs, rt) and shift amount for sll/srl
//   result, hi           main result; hi = product high half or remainder, else 0
//   zero, overflow       result==0, signed overflow for add/sub
//   div_by_zero          div attempted with b == 0
//   busy, done           busy while not idle; done pulses one cycle per completion
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               operation,
    input  logic [WIDTH-1:0]         a,
    input  logic [WIDTH-1:0]         b,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    output logic [WIDTH-1:0]         result,
    output logic [WIDTH-1:0]         hi,
    output logic                     zero,
    output logic                     overflow,
    output logic                     div_by_zero,
    output logic                     busy,
    output logic                     done
);

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_SUBU = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1110;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_MUL    = 2'd1,
        S_DIV    = 2'd2,
        S_FINISH = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    // Iteration datapath. The same two accumulators serve both engines:
    //   mul: acc_hi = running high half, acc_lo = multiplier shifting out / product low half
    //   div: acc_hi = partial remainder,  acc_lo = dividend shifting out / quotient bits in
    logic [CW-1:0]    iter_q;
    logic [WIDTH-1:0] opnd_q;     // |a| for mul (multiplicand), |b| for div (divisor)
    logic [WIDTH-1:0] acc_hi_q;
    logic [WIDTH-1:0] acc_lo_q;
    logic             neg_lo_q;   // negate product / quotient in FINISH
    logic             neg_hi_q;   // negate remainder in FINISH (follows sign of a)
    logic             is_mul_q;
    logic             dbz_q;
    logic [WIDTH-1:0] a_q;        // original dividend, reported in hi on divide by zero

    // ------------------------------------------------------------------
    // Single-cycle ALU
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sum_w;
    logic [WIDTH-1:0] diff_w;
    logic             add_ovf;
    logic             sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    always_comb begin
        sum_w   = a + b;
        diff_w  = a - b;
        // Sign of result disagreeing with a, given compatible operand signs.
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum_w[WIDTH-1]  != a[WIDTH-1]);
        sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff_w[WIDTH-1] != a[WIDTH-1]);
        alu_res = '0;
        alu_ovf = 1'b0;
        case (operation)
            OP_ADD: begin
                alu_res = sum_w;
                alu_ovf = add_ovf;
            end
            OP_SUB: begin
                alu_res = diff_w;
                alu_ovf = sub_ovf;
            end
            OP_ADDU: alu_res = sum_w;
            OP_SUBU: alu_res = diff_w;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_NOR:  alu_res = ~(a | b);
            OP_SLL:  alu_res = b << shamt;
            OP_SRL:  alu_res = b >> shamt;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            // Invalid codes (and mul/div, which never take this path) give 0.
            default: alu_res = '0;
        endcase
    end

    // Operand magnitudes for the unsigned iterative engines. The most negative
    // value maps to 2^(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    always_comb begin
        abs_a = a[WIDTH-1] ? (~a + 1'b1) : a;
        abs_b = b[WIDTH-1] ? (~b + 1'b1) : b;
    end

    // ------------------------------------------------------------------
    // Iteration step logic
    // ------------------------------------------------------------------
    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] div_shift;
    logic [WIDTH:0] div_trial;
    logic           div_ge;

    always_comb begin
        // Shift-add: add multiplicand when the current multiplier bit is set,
        // then shift the {carry, acc_hi, acc_lo} chain right by one.
        mul_sum = {1'b0, acc_hi_q};
        if (acc_lo_q[0]) begin
            mul_sum = {1'b0, acc_hi_q} + {1'b0, opnd_q};
        end
        // Restoring division: bring in the next dividend bit and try to
        // subtract the divisor; a borrow out of the top bit means "restore".
        div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_trial[WIDTH];
    end

    // ------------------------------------------------------------------
    // Final sign correction and result selection (used in FINISH)
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic [WIDTH-1:0]   fin_res;
    logic [WIDTH-1:0]   fin_hi;

    always_comb begin
        prod_mag    = {acc_hi_q, acc_lo_q};
        prod_signed = neg_lo_q ? (~prod_mag + 1'b1) : prod_mag;
        quo_signed  = neg_lo_q ? (~acc_lo_q + 1'b1) : acc_lo_q;
        rem_signed  = neg_hi_q ? (~acc_hi_q + 1'b1) : acc_hi_q;
        if (dbz_q) begin
            fin_res = '1;
            fin_hi  = a_q;
        end else if (is_mul_q) begin
            fin_res = prod_signed[WIDTH-1:0];
            fin_hi  = prod_signed[2*WIDTH-1:WIDTH];
        end else begin
            fin_res = quo_signed;
            fin_hi  = rem_signed;
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (operation == OP_MUL) begin
                        state_d = S_MUL;
                    end else if (operation == OP_DIV) begin
                        // Divide by zero skips the iteration entirely.
                        state_d = (b == '0) ? S_FINISH : S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (iter_q == LAST_ITER) begin
                    state_d = S_FINISH;
                end
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign busy = (state_q != S_IDLE);

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            iter_q      <= '0;
            opnd_q      <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            is_mul_q    <= 1'b0;
            dbz_q       <= 1'b0;
            a_q         <= '0;
            result      <= '0;
            hi          <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (operation == OP_MUL) begin
                            iter_q   <= '0;
                            opnd_q   <= abs_a;
                            acc_hi_q <= '0;
                            acc_lo_q <= abs_b;
                            neg_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_hi_q <= 1'b0;
                            is_mul_q <= 1'b1;
                            dbz_q    <= 1'b0;
                            a_q      <= a;
                        end else if (operation == OP_DIV) begin
                            iter_q   <= '0;
                            opnd_q   <= abs_b;
                            acc_hi_q <= '0;
                            acc_lo_q <= abs_a;
                            neg_lo_q <= a[WIDTH-1] ^ b[WIDTH-1];
                            neg_hi_q <= a[WIDTH-1];
                            is_mul_q <= 1'b0;
                            dbz_q    <= (b == '0);
                            a_q      <= a;
                        end else begin
                            result      <= alu_res;
                            hi          <= '0;
                            zero        <= (alu_res == '0);
                            overflow    <= alu_ovf;
                            div_by_zero <= 1'b0;
                            done        <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc_hi_q <= mul_sum[WIDTH:1];
                    acc_lo_q <= {mul_sum[0], acc_lo_q[WIDTH-1:1]};
                    iter_q   <= iter_q + CW'(1);
                end
                S_DIV: begin
                    acc_hi_q <= div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
                    acc_lo_q <= {acc_lo_q[WIDTH-2:0], div_ge};
                    iter_q   <= iter_q + CW'(1);
                end
                S_FINISH: begin
                    result      <= fin_res;
                    hi          <= fin_hi;
                    zero        <= (fin_res == '0);
                    overflow    <= 1'b0;
                    div_by_zero <= dbz_q;
                    done        <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle: the stimulus process queues the expected
// response for each accepted start; the monitor pops and compares on every done.
module tb_alu_multicycle;

    localparam int W = 32;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MUL  = 4'b0010;
    localparam logic [3:0] OP_DIV  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_ADDU = 4'b0110;
    localparam logic [3:0] OP_SUBU = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_XOR  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_SLT  = 4'b1110;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   operation;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   shamt;
    logic [W-1:0] result;
    logic [W-1:0] hi;
    logic         zero;
    logic         overflow;
    logic         div_by_zero;
    logic         busy;
    logic         done;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .operation   (operation),
        .a           (a),
        .b           (b),
        .shamt       (shamt),
        .result      (result),
        .hi          (hi),
        .zero        (zero),
        .overflow    (overflow),
        .div_by_zero (div_by_zero),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic [W-1:0] hi;
        logic         z;
        logic         ov;
        logic         dbz;
    } resp_t;

    resp_t exp_q[$];
    int    id_q[$];
    int    total  = 0;
    int    bad    = 0;
    int    op_id  = 0;

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        resp_t got;
        resp_t want;
        int    id;
        if (done === 1'b1) begin
            got = {result, hi, zero, overflow, div_by_zero};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: got done=1 res=%h at t=%0t, required no done", result, $time);
            end else begin
                want = exp_q.pop_front();
                id   = id_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("FAIL resp_op%0d: got res=%h hi=%h z=%b ov=%b dbz=%b, required res=%h hi=%h z=%b ov=%b dbz=%b",
                             id, got.res, got.hi, got.z, got.ov, got.dbz,
                             want.res, want.hi, want.z, want.ov, want.dbz);
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    // Issue one operation at the current negedge and wait (bounded) for done.
    // elat  = negedge index after the start edge at which done must appear.
    // ebusy = number of those negedges with busy high.
    // poke  = fire extra start pulses mid-operation, which must be ignored.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic [4:0] sh, input logic [W-1:0] er, input logic [W-1:0] eh,
                          input logic ez, input logic eov, input logic edbz,
                          input int elat, input int ebusy, input bit poke);
        int k;
        int busy_cnt;
        bit seen;
        operation = op;
        a         = va;
        b         = vb;
        shamt     = sh;
        start     = 1'b1;
        exp_q.push_back({er, eh, ez, eov, edbz});
        id_q.push_back(op_id);
        k        = 0;
        busy_cnt = 0;
        seen     = 1'b0;
        while (!seen && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) start = 1'b0;
            if (poke && k == 3) begin
                start     = 1'b1;
                operation = OP_ADD;
                a         = 32'd1;
                b         = 32'd1;
            end
            if (poke && k == 5) start = 1'b0;
            if (poke && k == 20) start = 1'b1;
            if (poke && k == 21) start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        start = 1'b0;
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout_op%0d: got no done in 100 cycles, required done at cycle %0d", op_id, elat);
            void'(exp_q.pop_back());
            void'(id_q.pop_back());
        end else begin
            check($sformatf("latency_op%0d", op_id), 64'(k), 64'(elat));
            check($sformatf("busy_cycles_op%0d", op_id), 64'(busy_cnt), 64'(ebusy));
        end
        @(negedge clk);
        check($sformatf("done_low_op%0d", op_id), 64'(done), 64'd0);
        op_id++;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        operation = 4'b0000;
        a         = '0;
        b         = '0;
        shamt     = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({result, hi, zero, overflow, div_by_zero, busy, done}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        //     op       a             b             sh     result        hi            z     ov    dbz   lat busy poke
        run_op(OP_ADD,  32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0,        1'b0, 1'b1, 1'b0, 1,  0,   0);
        run_op(OP_ADDU, 32'h7FFFFFFF, 32'h00000001, 5'd0,  32'h80000000, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_SUB,  32'd5,        32'd5,        5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_SUB,  32'h80000000, 32'h00000001, 5'd0,  32'h7FFFFFFF, 32'h0,        1'b0, 1'b1, 1'b0, 1,  0,   0);
        run_op(OP_SUBU, 32'h0,        32'h1,        5'd0,  32'hFFFFFFFF, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_SLT,  32'hFFFFFFFF, 32'h00000001, 5'd0,  32'h1,        32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_SLT,  32'h00000001, 32'hFFFFFFFF, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hF000F000, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'hFFF0FFF0, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h0FF00FF0, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 5'd0,  32'h000F000F, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_SLL,  32'h0,        32'h00000001, 5'd4,  32'h00000010, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_SRL,  32'h0,        32'hF0000000, 5'd4,  32'h0F000000, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_SRL,  32'h0,        32'h80000000, 5'd31, 32'h00000001, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(4'b1100, 32'd5,        32'd6,        5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1,  0,   0);
        run_op(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_MUL,  32'hFFFFFFFE, 32'd3,        5'd0,  32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 34, 33,  1);
        run_op(OP_MUL,  32'h12345678, 32'h10,       5'd0,  32'h23456780, 32'h00000001, 1'b0, 1'b0, 1'b0, 34, 33,  0);
        run_op(OP_MUL,  32'hFFFFFFFD, 32'hFFFFFFFB, 5'd0,  32'h0000000F, 32'h0,        1'b0, 1'b0, 1'b0, 34, 33,  0);
        run_op(OP_MUL,  32'h80000000, 32'h80000000, 5'd0,  32'h0,        32'h40000000, 1'b1, 1'b0, 1'b0, 34, 33,  0);
        run_op(OP_DIV,  32'hFFFFFFF9, 32'd2,        5'd0,  32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 34, 33,  1);
        run_op(OP_DIV,  32'd100,      32'd7,        5'd0,  32'h0000000E, 32'h00000002, 1'b0, 1'b0, 1'b0, 34, 33,  0);
        run_op(OP_DIV,  32'd7,        32'hFFFFFFFE, 5'd0,  32'hFFFFFFFD, 32'h00000001, 1'b0, 1'b0, 1'b0, 34, 33,  0);
        run_op(OP_DIV,  32'd9,        32'd0,        5'd0,  32'hFFFFFFFF, 32'h00000009, 1'b0, 1'b0, 1'b1, 2,  1,   0);
        run_op(OP_ADD,  32'd1,        32'd2,        5'd0,  32'h00000003, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);
        run_op(OP_MUL,  32'd6,        32'd7,        5'd0,  32'h0000002A, 32'h0,        1'b0, 1'b0, 1'b0, 34, 33,  0);

        // Abort a divide around iteration 10: no expectation is queued, so any
        // done from it is flagged by the monitor.
        operation = OP_DIV;
        a         = 32'd100;
        b         = 32'd7;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_before_abort", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_outputs", 64'({result, hi, zero, overflow, div_by_zero, busy, done}), 64'd0);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("idle_after_abort", 64'({busy, done}), 64'd0);

        run_op(OP_SLL,  32'h0,        32'h00000001, 5'd4,  32'h00000010, 32'h0,        1'b0, 1'b0, 1'b0, 1,  0,   0);

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning datapath width; iterative mul/div runs WIDTH steps.
REQ-002 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have start  input  1  request to begin an operation; sampled only in IDLE.
REQ-005 SHALL have operation  input  4  ALU operation code from the ALU control stage.
REQ-006 SHALL have a, b  input  WIDTH each  source operands (rs, rt).
REQ-007 SHALL have shamt  input  log2(WIDTH)  shift amount for sll/srl.
REQ-008 SHALL have result  output  WIDTH  main result; product low half or quotient for mul/div.
REQ-009 SHALL have hi  output  WIDTH  product high half (mul) or remainder (div); 0 for other ops.
REQ-010 SHALL have zero  output  1  high when result == 0.
REQ-011 SHALL have overflow  output  1  signed overflow flag for add/sub.
REQ-012 SHALL have div_by_zero  output  1  div with b == 0.
REQ-013 SHALL have busy  output  1  high while not in IDLE.
REQ-014 SHALL have done  output  1  one-cycle pulse; result and flags valid.

Function
REQ-015 SHALL decode operation: 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 sll, 0101 srl, 0110 addu, 0111 subu, 1000 and, 1001 or, 1010 xor, 1011 nor, 1110 slt, 1100/1101/1111 invalid.
REQ-016 SHALL implement FSM states IDLE, MUL, DIV, FINISH; reset and every completion return to IDLE.
REQ-017 SHALL accept start only in IDLE; start while busy SHALL be ignored, no effect on the running operation.
REQ-018 Single-cycle ops: start sampled at edge E0 SHALL register result, flags and done=1 at E0; FSM stays IDLE; latency 1.
REQ-019 mul/div: E0 SHALL latch operands and enter MUL/DIV, which runs WIDTH iteration edges (E1..E_WIDTH), then FINISH; result/hi/flags/done SHALL be written at E_WIDTH+1 (E33 for WIDTH=32).
REQ-020 done SHALL be high for exactly one cycle per accepted start, low otherwise.
REQ-021 result, hi and flags SHALL hold their values until the next accepted start's completion.
REQ-022 add/sub SHALL be two's complement modulo 2^WIDTH; overflow=1 when operand signs match (add) or differ (sub) and the result sign differs from a.
REQ-023 addu/subu SHALL equal add/sub arithmetically, with overflow forced 0.
REQ-024 and/or/xor/nor SHALL be bitwise; sll/srl SHALL shift b by shamt (srl zero-fills); slt SHALL give 1 if signed a < signed b, else 0.
REQ-025 mul SHALL be signed shift-add on magnitudes with final sign correction in FINISH: {hi,result} = full 2*WIDTH signed product.
REQ-026 div SHALL be signed restoring division on magnitudes: quotient truncated toward zero; remainder sign follows a.
REQ-027 div with b == 0 SHALL skip iteration: done at E0+1 via FINISH, result=all ones, hi=a, div_by_zero=1.
REQ-028 Invalid codes SHALL complete in 1 cycle with result=0, hi=0, overflow=0, zero=1.
REQ-029 zero SHALL be computed from the registered result at the same edge as result.
REQ-030 overflow and div_by_zero SHALL be 0 for every op not named above.

Reset
REQ-031 reset SHALL force IDLE and clear result, hi, zero, overflow, div_by_zero, busy, done to 0, and SHALL take priority over start.
REQ-032 reset during MUL/DIV/FINISH SHALL abort the operation at that edge with no done pulse.

Verification
REQ-033 add a=0x7FFFFFFF, b=1 -> next cycle result=0x80000000, overflow=1, done=1 for one cycle; addu same operands -> overflow=0.
REQ-034 sub a=5, b=5 -> result=0, zero=1; slt a=0xFFFFFFFF, b=1 -> result=1.
REQ-035 mul a=0xFFFFFFFE (-2), b=3 -> busy for 33 cycles, done after E33, hi=0xFFFFFFFF, result=0xFFFFFFFA; start pulses mid-op ignored.
REQ-036 div a=-7, b=2 -> result=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); div a=9, b=0 -> done after E1, result=0xFFFFFFFF, hi=9, div_by_zero=1.
REQ-037 reset at iteration 10 of a div -> all outputs 0 next cycle, no done; new start sll b=1, shamt=4 -> result=0x10.
